ifetch: RTL

Instruction fetch stage of the pipelined MIPS core. Owns the fetch PC, issues word reads to the synchronous instruction memory and buffers returned words in a small queue. Presents one {pc, instruction} pair per cycle to the decoder, and absorbs decoder stalls and EX-stage branch redirects without dropping or duplicating instructions.

---
 rtl/ifetch_pkg.sv | 25 ++
 rtl/ifetch_if.sv | 25 ++
 rtl/ifetch_queue.sv | 51 +++++
 rtl/ifetch.sv | 97 +++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared defines for the instruction fetch stage
package ifetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    localparam logic [7:0] TRAP_NONE        = 8'h00;
    localparam logic [7:0] TRAP_STALL       = 8'h01;
    localparam logic [7:0] TRAP_IF_MISALIGN = 8'h02;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
        logic [7:0]  exc;
    } fetch_entry_t;

    function automatic logic misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ifetch_if.sv
// rtl/ifetch_if.sv - instruction memory, redirect and decode-side signals of the fetch stage
interface ifetch_if #(
    parameter int AW = 10
);
    logic          im_req;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_rdata;
    logic          br_enable;
    logic [31:0]   br_target;
    logic          id_stall;
    logic          if_valid;
    logic [31:0]   if_pc;
    logic [31:0]   if_ir;
    logic [7:0]    if_exception;

    modport master (
        output im_req, im_addr, if_valid, if_pc, if_ir, if_exception,
        input  im_rdata, br_enable, br_target, id_stall
    );

    modport slave (
        input  im_req, im_addr, if_valid, if_pc, if_ir, if_exception,
        output im_rdata, br_enable, br_target, id_stall
    );
endinterface

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - circular FIFO of fetched {pc, ir, exc} entries
module ifetch_queue import ifetch_pkg::*; #(
    parameter  int QDEPTH = 2,
    localparam int CW     = $clog2(QDEPTH + 1),
    localparam int PW     = $clog2(QDEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    output logic [CW-1:0] count,
    output fetch_entry_t  head
);

    fetch_entry_t   mem [QDEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (32'(p) == QDEPTH - 1) ? PW'(0) : p + PW'(1);
    endfunction

    // A push during flush lands in slot 0 of the freshly emptied queue
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= push ? PW'(1) : PW'(0);
            count  <= push ? CW'(1) : CW'(0);
        end else begin
            if (push)
                wr_ptr <= next_ptr(wr_ptr);
            if (pop)
                rd_ptr <= next_ptr(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[flush ? PW'(0) : wr_ptr] <= push_data;
    end

    assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/ifetch.sv
// rtl/ifetch.sv - fetch PC, request credit logic, redirect/fault FSM and decode-side queue
module ifetch import ifetch_pkg::*; #(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          QDEPTH   = 2,
    parameter int          AW       = 10
) (
    input  logic     clk,
    input  logic     rst,
    ifetch_if.master bus
);

    localparam int CW = $clog2(QDEPTH + 1);

    fetch_state_t  state;
    fetch_state_t  state_nxt;
    logic [31:0]   fpc;
    logic [31:0]   inflight_pc;
    logic          inflight;
    logic          issue;
    logic          pop;
    logic          br_misalign;
    logic          q_push;
    logic          q_pop;
    fetch_entry_t  q_data;
    logic [CW-1:0] count;
    fetch_entry_t  head;

    assign br_misalign = misaligned(bus.br_target);
    assign pop         = bus.if_valid && !bus.id_stall;
    assign q_pop       = pop && !bus.br_enable;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_RUN;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.br_enable)
            state_nxt = br_misalign ? ST_FAULT : ST_RUN;
    end

    // Entries owned (queued + inflight) after this cycle's pop must stay below QDEPTH
    always_comb begin
        issue = 1'b0;
        if (rst && state == ST_RUN && !bus.br_enable)
            issue = (32'(count) + 32'(inflight)) < (32'(QDEPTH) + 32'(pop));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fpc         <= RESET_PC;
            inflight_pc <= '0;
            inflight    <= 1'b0;
        end else if (bus.br_enable) begin
            fpc      <= bus.br_target;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fpc;
                fpc         <= fpc + 32'd4;
            end
        end
    end

    // A redirect squashes the arriving response; only a misaligned target pushes
    always_comb begin
        q_push = inflight;
        q_data = '{pc: inflight_pc, ir: bus.im_rdata, exc: TRAP_NONE};
        if (bus.br_enable) begin
            q_push = br_misalign;
            q_data = '{pc: bus.br_target, ir: 32'h0, exc: TRAP_IF_MISALIGN};
        end
    end

    ifetch_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.br_enable),
        .push      (q_push),
        .push_data (q_data),
        .pop       (q_pop),
        .count     (count),
        .head      (head)
    );

    assign bus.im_req       = issue;
    assign bus.im_addr      = fpc[AW+1:2];
    assign bus.if_valid     = count != '0;
    assign bus.if_pc        = head.pc;
    assign bus.if_ir        = head.ir;
    assign bus.if_exception = head.exc;

endmodule
